// File: rtl/execute_stage_pipelined.sv
// Execute stage with EX/MEM register: forwarding, ALU, branch/JALR redirect, flush.
// Define EXECUTE_STAGE_MDU_EN to build the iterative multiply/divide unit.
module execute_stage_pipelined #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ValidE,
   input  logic            RegWriteE,
   input  logic            MemWriteE,
   input  logic            JumpE,
   input  logic            JalrE,
   input  logic            BranchE,
   input  logic            ALUSrcE,
   input  logic [1:0]      ResultSrcE,
   input  logic [3:0]      ALUControlE,
   input  logic [2:0]      BranchOpE,
   input  logic            MdEnE,
   input  logic [2:0]      MdOpE,
   input  logic [1:0]      ForwardAE,
   input  logic [1:0]      ForwardBE,
   input  logic [XLEN-1:0] RD1E,
   input  logic [XLEN-1:0] RD2E,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] ExtImmE,
   input  logic [XLEN-1:0] PCPlus4E,
   input  logic [4:0]      RdE,
   input  logic [XLEN-1:0] ResultW,
   input  logic            FlushE,
   output logic            BusyE,
   output logic            PCSrcE,
   output logic [XLEN-1:0] PCTargetE,
   output logic            RegWriteM,
   output logic            MemWriteM,
   output logic            ValidM,
   output logic            IllegalOpM,
   output logic [1:0]      ResultSrcM,
   output logic [XLEN-1:0] ALUResultM,
   output logic [XLEN-1:0] WriteDataM,
   output logic [XLEN-1:0] PCPlus4M,
   output logic [4:0]      RdM
);
   localparam int unsigned SHW = $clog2(XLEN);

   logic [XLEN-1:0] srca, writedata, srcb, aluresult, exresult, jalrsum;
   logic [SHW-1:0]  shamt;
   logic            taken, regwr, illegal;

   always_comb begin
      case (ForwardAE)
         2'b00:   srca = RD1E;
         2'b01:   srca = ResultW;
         2'b10:   srca = ALUResultM;
         default: srca = '0;
      endcase
      case (ForwardBE)
         2'b00:   writedata = RD2E;
         2'b01:   writedata = ResultW;
         2'b10:   writedata = ALUResultM;
         default: writedata = '0;
      endcase
   end

   assign srcb  = ALUSrcE ? ExtImmE : writedata;
   assign shamt = srcb[SHW-1:0];

   always_comb begin
      aluresult = '0;
      case (ALUControlE)
         4'b0000: aluresult = srca + srcb;
         4'b0001: aluresult = srca - srcb;
         4'b0010: aluresult = srca & srcb;
         4'b0011: aluresult = srca | srcb;
         4'b0100: aluresult = srca ^ srcb;
         4'b0101: aluresult = {{(XLEN-1){1'b0}}, ($signed(srca) < $signed(srcb))};
         4'b0110: aluresult = {{(XLEN-1){1'b0}}, (srca < srcb)};
         4'b0111: aluresult = srca << shamt;
         4'b1000: aluresult = srca >> shamt;
         4'b1001: aluresult = $unsigned($signed(srca) >>> shamt);
         default: aluresult = '0;
      endcase
   end

   // Branches compare the two forwarded registers, never the immediate.
   always_comb begin
      taken = 1'b0;
      case (BranchOpE)
         3'b000:  taken = (srca == writedata);
         3'b001:  taken = (srca != writedata);
         3'b100:  taken = ($signed(srca) <  $signed(writedata));
         3'b101:  taken = ($signed(srca) >= $signed(writedata));
         3'b110:  taken = (srca <  writedata);
         3'b111:  taken = (srca >= writedata);
         default: taken = 1'b0;
      endcase
   end

   assign jalrsum   = srca + ExtImmE;
   assign PCSrcE    = ValidE & ~FlushE & (JumpE | (BranchE & taken));
   assign PCTargetE = JalrE ? {jalrsum[XLEN-1:1], 1'b0} : (PCE + ExtImmE);

`ifdef EXECUTE_STAGE_MDU_EN
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;

   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  acc, q, d, amag, bmag, mduresult;
   logic [XLEN:0]    trial;
   logic [1:0]       op;
   logic             neg_q, neg_r, issue, is_div, sgn, sgn_a, sgn_b, divzero, ovf;

   assign issue   = (state == IDLE) & ValidE & MdEnE & ~FlushE;
   assign is_div  = MdOpE[2];
   assign sgn     = is_div & ~MdOpE[0];
   assign sgn_a   = sgn & srca[XLEN-1];
   assign sgn_b   = sgn & writedata[XLEN-1];
   assign amag    = sgn_a ? -srca : srca;
   assign bmag    = sgn_b ? -writedata : writedata;
   assign divzero = is_div & (writedata == '0);
   assign ovf     = sgn & (srca == {1'b1, {(XLEN-1){1'b0}}}) & (writedata == '1);
   assign trial   = {acc, q[XLEN-1]} - {1'b0, d};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      BusyE    = 1'b0;
      case (state)
         IDLE: if (issue) begin
            BusyE    = 1'b1;
            state_nx = (divzero | ovf) ? DONE : RUN;
         end
         RUN: begin
            BusyE = 1'b1;
            if (FlushE)                        state_nx = IDLE;
            else if (cnt == CNT_W'(XLEN - 1))  state_nx = DONE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Special cases preload acc/q so the DONE-state sign fix yields the architectural result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0; acc <= '0; q <= '0; d <= '0;
         op <= '0; neg_q <= 1'b0; neg_r <= 1'b0;
      end else if (issue) begin
         cnt <= '0;
         op  <= MdOpE[2:1];
         if (divzero) begin
            acc <= srca; q <= '1; neg_q <= 1'b0; neg_r <= 1'b0;
         end else if (ovf) begin
            acc <= '0; q <= srca; neg_q <= 1'b0; neg_r <= 1'b0;
         end else if (is_div) begin
            acc <= '0; q <= amag; d <= bmag; neg_q <= sgn_a ^ sgn_b; neg_r <= sgn_a;
         end else begin
            acc <= '0; q <= writedata; d <= srca; neg_q <= 1'b0; neg_r <= 1'b0;
         end
      end else if (state == RUN) begin
         cnt <= cnt + CNT_W'(1);
         if (!op[1]) begin
            if (q[0]) acc <= acc + d;
            d <= d << 1;
            q <= q >> 1;
         end else if (!trial[XLEN]) begin
            acc <= trial[XLEN-1:0];
            q   <= {q[XLEN-2:0], 1'b1};
         end else begin
            acc <= {acc[XLEN-2:0], q[XLEN-1]};
            q   <= {q[XLEN-2:0], 1'b0};
         end
      end
   end

   always_comb begin
      if (!op[1])     mduresult = acc;
      else if (!op[0]) mduresult = neg_q ? -q : q;
      else            mduresult = neg_r ? -acc : acc;
   end

   assign exresult = MdEnE ? mduresult : aluresult;
   assign regwr    = RegWriteE;
   assign illegal  = 1'b0;
`else
   logic             unused_mdop;
   logic [CNT_W-1:0] unused_cnt;

   assign unused_mdop = ^MdOpE;
   assign unused_cnt  = '0;
   assign BusyE       = 1'b0;
   assign exresult    = MdEnE ? '0 : aluresult;
   assign regwr       = RegWriteE & ~MdEnE;
   assign illegal     = MdEnE;
`endif

   // Bubbles clear only the control bits; data fields hold their last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RegWriteM  <= 1'b0;
         MemWriteM  <= 1'b0;
         ValidM     <= 1'b0;
         IllegalOpM <= 1'b0;
         ResultSrcM <= '0;
         ALUResultM <= '0;
         WriteDataM <= '0;
         PCPlus4M   <= '0;
         RdM        <= '0;
      end else if (BusyE | FlushE | ~ValidE) begin
         RegWriteM  <= 1'b0;
         MemWriteM  <= 1'b0;
         ValidM     <= 1'b0;
         IllegalOpM <= 1'b0;
      end else begin
         RegWriteM  <= regwr;
         MemWriteM  <= MemWriteE;
         ValidM     <= 1'b1;
         IllegalOpM <= illegal;
         ResultSrcM <= ResultSrcE;
         ALUResultM <= exresult;
         WriteDataM <= writedata;
         PCPlus4M   <= PCPlus4E;
         RdM        <= RdE;
      end
   end
endmodule
